// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity serial receive path.
package odd_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    OUT
  } rx_state_t;

  localparam int DATA_W_DEFAULT = 16;

  // High when data plus parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(
    input logic [DATA_W_DEFAULT-1:0] data,
    input logic                      par
  );
    return ^{data, par};
  endfunction

endpackage

// File: rtl/odd_parity_frame_rx_if.sv
// Serial input and word output bundle of the odd-parity frame receiver.
interface odd_parity_frame_rx_if #(
  parameter int DATA_W   = 16,
  parameter int ERRCNT_W = 8
);

  logic                bit_valid;
  logic                ser_in;
  logic                sof;
  logic [DATA_W-1:0]   data_out;
  logic                par_bit;
  logic                parity_err;
  logic                out_valid;
  logic                out_ready;
  logic                frame_abort;
  logic                overrun;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    input  bit_valid,
    input  ser_in,
    input  sof,
    input  out_ready,
    output data_out,
    output par_bit,
    output parity_err,
    output out_valid,
    output frame_abort,
    output overrun,
    output err_count
  );

  modport slave (
    output bit_valid,
    output ser_in,
    output sof,
    output out_ready,
    input  data_out,
    input  par_bit,
    input  parity_err,
    input  out_valid,
    input  frame_abort,
    input  overrun,
    input  err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/odd_parity_frame_rx.sv
// LSB-first serial frame receiver with incremental odd-parity check,
// valid/ready word output, abort/overrun pulses and an error counter.
module odd_parity_frame_rx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ERRCNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  odd_parity_frame_rx_if.master bus
);

  localparam int CW = $clog2(DATA_W + 1);

  rx_state_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] data_q;
  logic              x_q;
  logic              par_q;
  logic              perr_q;
  logic              valid_q;
  logic              abort_q;
  logic              ovr_q;

  logic              hs;
  logic              start;
  logic              in_frame;
  logic              restart;
  logic [DATA_W-1:0] bit0;
  logic [ERRCNT_W-1:0] errcnt;

  assign hs       = valid_q & bus.out_ready;
  assign start    = bus.bit_valid & bus.sof;
  assign in_frame = (state_q == DATA) || (state_q == PAR);
  // A sof while a word is still held is an overrun, not a restart
  assign restart  = start & ((state_q != OUT) | hs);
  assign bit0     = DATA_W'(bus.ser_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      x_q     <= 1'b0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      ovr_q   <= 1'b0;
      if (hs) begin
        valid_q <= 1'b0;
      end
      if (restart) begin
        sh_q    <= bit0;
        x_q     <= bus.ser_in;
        cnt_q   <= CW'(1);
        state_q <= DATA;
        abort_q <= in_frame;
      end else begin
        unique case (state_q)
          DATA: begin
            if (bus.bit_valid) begin
              sh_q  <= sh_q | (bit0 << cnt_q);
              x_q   <= x_q ^ bus.ser_in;
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == CW'(DATA_W - 1)) begin
                state_q <= PAR;
              end
            end
          end
          PAR: begin
            if (bus.bit_valid) begin
              data_q  <= sh_q;
              par_q   <= bus.ser_in;
              perr_q  <= ~(x_q ^ bus.ser_in);
              valid_q <= 1'b1;
              state_q <= OUT;
            end
          end
          OUT: begin
            if (hs) begin
              state_q <= IDLE;
            end else if (start) begin
              ovr_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERRCNT_W)
  ) u_errcnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (hs & perr_q),
    .count_o(errcnt)
  );

  assign bus.data_out    = data_q;
  assign bus.par_bit     = par_q;
  assign bus.parity_err  = perr_q;
  assign bus.out_valid   = valid_q;
  assign bus.frame_abort = abort_q;
  assign bus.overrun     = ovr_q;
  assign bus.err_count   = errcnt;

endmodule
